// File: rtl/riscv_trace_pkg.sv
// Shared types and default classification table for the retire-stream tracer.
// The table is priority ordered: lower indices win when several entries match.
package riscv_trace_pkg;

    localparam int XLEN                = 32;
    localparam int DEFAULT_NUM_CLASSES = 8;
    localparam int CLS_MAX_W           = 5;

    localparam int CLS_MULDIV = 0;
    localparam int CLS_ALU    = 1;
    localparam int CLS_BRANCH = 2;
    localparam int CLS_LOAD   = 3;
    localparam int CLS_STORE  = 4;
    localparam int CLS_SYSTEM = 5;
    localparam int CLS_FP     = 6;
    localparam int CLS_OTHER  = 7;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      instr;
        logic [CLS_MAX_W-1:0] cls;
    } trace_rec_t;

    // Packed concatenation lists the highest index first (OTHER .. MULDIV).
    // The ALU mask drops opcode bit 5 so both OP and OP-IMM land in class 1.
    localparam logic [DEFAULT_NUM_CLASSES-1:0][XLEN-1:0] DEFAULT_MASK = {
        32'h0000_0000, 32'h0000_007F, 32'h0000_007F, 32'h0000_007F,
        32'h0000_007F, 32'h0000_007F, 32'h0000_005F, 32'hFE00_007F
    };

    localparam logic [DEFAULT_NUM_CLASSES-1:0][XLEN-1:0] DEFAULT_MATCH = {
        32'h0000_0000, 32'h0000_0053, 32'h0000_0073, 32'h0000_0023,
        32'h0000_0003, 32'h0000_0063, 32'h0000_0013, 32'h0200_0033
    };

endpackage

// File: rtl/riscv_trace_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is visible on pop_data
// whenever empty is low. Pointers carry one extra bit to tell full from empty.
module riscv_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr_reg;
    logic [AW:0]           rd_ptr_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/riscv_trace_classifier.sv
// Retire-stream tracer: samples retired instructions, classifies them against a
// mask/match table, counts per class and queues trace records for the debug unit.
module riscv_trace_classifier
    import riscv_trace_pkg::*;
#(
    parameter int NUM_CLASSES = 8,
    parameter logic [NUM_CLASSES-1:0][31:0] CLASS_MASK  = DEFAULT_MASK,
    parameter logic [NUM_CLASSES-1:0][31:0] CLASS_MATCH = DEFAULT_MATCH,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          retire_valid_i,
    input  logic [31:0]                   retire_pc_i,
    input  logic [31:0]                   retire_instr_i,
    output logic                          trace_valid_o,
    input  logic                          trace_ready_i,
    output logic [31:0]                   trace_pc_o,
    output logic [31:0]                   trace_instr_o,
    output logic [CLS_W-1:0]              trace_class_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    input  logic [CLS_W-1:0]              cnt_sel_i,
    output logic [CNT_WIDTH-1:0]          cnt_value_o,
    input  logic                          cnt_clear_i,
    output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

    localparam int NSEL = 1 << CLS_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   sample_valid_reg;
    logic [31:0]            sample_pc_reg;
    logic [31:0]            sample_instr_reg;
    logic [NUM_CLASSES-1:0] hit;
    logic [CLS_W-1:0]       cls_id;
    logic [CNT_WIDTH-1:0]   cnt_reg  [NUM_CLASSES];
    logic [CNT_WIDTH-1:0]   cnt_next [NUM_CLASSES];
    logic [CNT_WIDTH-1:0]   sel_table [NSEL];
    logic [CNT_WIDTH-1:0]   cnt_value_reg;
    logic [CNT_WIDTH-1:0]   drop_cnt_reg;
    logic [CNT_WIDTH-1:0]   drop_cnt_next;
    trace_rec_t             push_rec;
    trace_rec_t             head_rec;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_valid_reg <= 1'b0;
            sample_pc_reg    <= '0;
            sample_instr_reg <= '0;
        end else begin
            sample_valid_reg <= enable_i && retire_valid_i;
            if (enable_i && retire_valid_i) begin
                sample_pc_reg    <= retire_pc_i;
                sample_instr_reg <= retire_instr_i;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_hit
            assign hit[gi] = ((sample_instr_reg & CLASS_MASK[gi]) == CLASS_MATCH[gi]);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        cls_id = CLS_W'(NUM_CLASSES - 1);
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                cls_id = CLS_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_next[i] = cnt_reg[i];
            if (cnt_clear_i) begin
                cnt_next[i] = '0;
            end else if (sample_valid_reg && (cls_id == CLS_W'(i)) && (cnt_reg[i] != CNT_MAX)) begin
                cnt_next[i] = cnt_reg[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (!rst_n) begin
                cnt_reg[i] <= '0;
            end else begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    // Readout registers the next-state value so an increment shows up on the
    // same cycle its trace record becomes visible.
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_sel
            if (gi < NUM_CLASSES) begin : g_live
                assign sel_table[gi] = cnt_next[gi];
            end else begin : g_pad
                assign sel_table[gi] = '0;
            end
        end
    endgenerate

    assign pop  = trace_valid_o && trace_ready_i;
    assign drop = sample_valid_reg && fifo_full && !pop;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (cnt_clear_i) begin
            drop_cnt_next = '0;
        end else if (drop && (drop_cnt_reg != CNT_MAX)) begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_value_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            cnt_value_reg <= sel_table[cnt_sel_i];
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    always_comb begin
        push_rec       = '0;
        push_rec.pc    = sample_pc_reg;
        push_rec.instr = sample_instr_reg;
        push_rec.cls   = CLS_MAX_W'(cls_id);
    end

    riscv_trace_fifo #(
        .DATA_WIDTH ($bits(trace_rec_t)),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sample_valid_reg),
        .push_data (push_rec),
        .pop       (pop),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

    // Head fields are masked while empty so stale RAM contents never leak out.
    assign trace_valid_o = !fifo_empty;
    assign trace_pc_o    = trace_valid_o ? head_rec.pc    : '0;
    assign trace_instr_o = trace_valid_o ? head_rec.instr : '0;
    assign trace_class_o = trace_valid_o ? CLS_W'(head_rec.cls) : '0;
    assign cnt_value_o   = cnt_value_reg;
    assign drop_cnt_o    = drop_cnt_reg;

endmodule

// File: tb/tb_riscv_trace_classifier.sv
// Bench for riscv_trace_classifier: table of classified instructions plus
// hand-written sequences for latency, full FIFO, clear, saturation and reset.
module tb_riscv_trace_classifier;

    localparam int NC    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int CLS_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable_i;
    logic              retire_valid_i;
    logic [31:0]       retire_pc_i;
    logic [31:0]       retire_instr_i;
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [31:0]       trace_pc_o;
    logic [31:0]       trace_instr_o;
    logic [CLS_W-1:0]  trace_class_o;
    logic [3:0]        fifo_level_o;
    logic [CLS_W-1:0]  cnt_sel_i;
    logic [CW-1:0]     cnt_value_o;
    logic              cnt_clear_i;
    logic [CW-1:0]     drop_cnt_o;

    always #5 clk = ~clk;

    riscv_trace_classifier #(
        .NUM_CLASSES (NC),
        .FIFO_DEPTH  (DEPTH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .retire_valid_i (retire_valid_i),
        .retire_pc_i    (retire_pc_i),
        .retire_instr_i (retire_instr_i),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_pc_o     (trace_pc_o),
        .trace_instr_o  (trace_instr_o),
        .trace_class_o  (trace_class_o),
        .fifo_level_o   (fifo_level_o),
        .cnt_sel_i      (cnt_sel_i),
        .cnt_value_o    (cnt_value_o),
        .cnt_clear_i    (cnt_clear_i),
        .drop_cnt_o     (drop_cnt_o)
    );

    typedef struct {
        logic [31:0] instr;
        int          cls;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cls;
    } rec_t;

    vec_t vecs [10];
    rec_t sb [$];
    int   exp_cnt [NC];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; any head popped on this edge is compared with the scoreboard.
    task automatic step();
        logic        pop_now;
        logic [31:0] hpc;
        logic [31:0] hin;
        int          hcls;
        rec_t        e;
        pop_now = trace_valid_o && trace_ready_i;
        hpc     = trace_pc_o;
        hin     = trace_instr_o;
        hcls    = int'(trace_class_o);
        @(posedge clk);
        #1;
        if (pop_now) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: popped pc=0x%08h with no record expected", hpc);
            end else begin
                e = sb.pop_front();
                if (hpc !== e.pc || hin !== e.instr || hcls != e.cls) begin
                    errors++;
                    $display("FAIL record: got pc=0x%08h instr=0x%08h cls=%0d expected pc=0x%08h instr=0x%08h cls=%0d",
                             hpc, hin, hcls, e.pc, e.instr, e.cls);
                end else begin
                    $display("pop pc=0x%08h instr=0x%08h cls=%0d", hpc, hin, hcls);
                end
            end
        end
    endtask

    task automatic retire(input logic [31:0] pc, input int idx, input bit accepted);
        rec_t r;
        retire_valid_i = 1'b1;
        retire_pc_i    = pc;
        retire_instr_i = vecs[idx].instr;
        if (accepted) begin
            r.pc    = pc;
            r.instr = vecs[idx].instr;
            r.cls   = vecs[idx].cls;
            sb.push_back(r);
        end
        if (exp_cnt[vecs[idx].cls] < 15) exp_cnt[vecs[idx].cls]++;
        step();
        retire_valid_i = 1'b0;
    endtask

    task automatic zero_model();
        for (int c = 0; c < NC; c++) exp_cnt[c] = 0;
    endtask

    task automatic read_cnts(input string tag);
        for (int c = 0; c < NC; c++) begin
            cnt_sel_i = CLS_W'(c);
            step();
            check($sformatf("%s_cnt%0d", tag, c), 64'(cnt_value_o), 64'(exp_cnt[c]));
        end
    endtask

    initial begin
        int sum;
        vecs[0] = '{32'h023100B3, 0};   // mul
        vecs[1] = '{32'h003100B3, 1};   // add
        vecs[2] = '{32'h00000063, 2};   // beq
        vecs[3] = '{32'h0000A083, 3};   // lw
        vecs[4] = '{32'h0020A023, 4};   // sw
        vecs[5] = '{32'h00000073, 5};   // ecall
        vecs[6] = '{32'h00000053, 6};   // fadd.s
        vecs[7] = '{32'h000000B7, 7};   // lui
        vecs[8] = '{32'h0220D0B3, 0};   // divu
        vecs[9] = '{32'h00100093, 1};   // addi
        zero_model();

        rst_n = 1'b0; enable_i = 1'b0; retire_valid_i = 1'b0; retire_pc_i = '0;
        retire_instr_i = '0; trace_ready_i = 1'b0; cnt_sel_i = '0; cnt_clear_i = 1'b0;
        step(); step();
        check("rst_valid", 64'(trace_valid_o), 64'd0);
        check("rst_pc",    64'(trace_pc_o),    64'd0);
        check("rst_instr", 64'(trace_instr_o), 64'd0);
        check("rst_class", 64'(trace_class_o), 64'd0);
        check("rst_level", 64'(fifo_level_o),  64'd0);
        check("rst_cnt",   64'(cnt_value_o),   64'd0);
        check("rst_drop",  64'(drop_cnt_o),    64'd0);
        rst_n = 1'b1; enable_i = 1'b1;
        step();

        // Latency: visible two edges after being driven, counter along with it.
        retire(32'h100, 0, 1'b1);
        check("lat_valid_early", 64'(trace_valid_o), 64'd0);
        step();
        check("lat_valid", 64'(trace_valid_o), 64'd1);
        check("lat_class", 64'(trace_class_o), 64'd0);
        check("lat_pc",    64'(trace_pc_o),    64'h100);
        check("lat_cnt0",  64'(cnt_value_o),   64'd1);
        trace_ready_i = 1'b1;
        step();
        cnt_clear_i = 1'b1; step(); cnt_clear_i = 1'b0; zero_model();

        // Table: every vector back-to-back with the consumer always ready.
        for (int i = 0; i < 10; i++) retire(32'h1000 + 32'(4 * i), i, 1'b1);
        step(); step(); step();
        check("tbl_drained", 64'(sb.size()), 64'd0);
        read_cnts("tbl");
        cnt_clear_i = 1'b1; step(); cnt_clear_i = 1'b0; zero_model();

        // Overflow: ten retires into a stalled FIFO of eight.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) retire(32'h2000 + 32'(4 * i), i, i < DEPTH);
        step(); step();
        check("full_level", 64'(fifo_level_o), 64'd8);
        check("full_drop",  64'(drop_cnt_o),   64'd2);
        read_cnts("full");
        sum = 0;
        for (int c = 0; c < NC; c++) begin
            cnt_sel_i = CLS_W'(c);
            step();
            sum += int'(cnt_value_o);
        end
        check("full_cnt_total", 64'(sum), 64'd10);

        // Push and pop on the same edge while full.
        retire(32'h3000, 1, 1'b1);
        trace_ready_i = 1'b1;
        step();
        trace_ready_i = 1'b0;
        check("pp_level", 64'(fifo_level_o), 64'd8);
        check("pp_drop",  64'(drop_cnt_o),   64'd2);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("pp_level_empty", 64'(fifo_level_o), 64'd0);
        check("pp_drained",     64'(sb.size()),    64'd0);

        // Clear coincides with the counting edge of a retire.
        retire(32'h4000, 0, 1'b1);
        cnt_clear_i = 1'b1;
        step();
        cnt_clear_i = 1'b0;
        zero_model();
        check("clr_drop", 64'(drop_cnt_o), 64'd0);
        read_cnts("clr");

        // Saturation at 4-bit all-ones.
        for (int i = 0; i < 15; i++) retire(32'h5000 + 32'(4 * i), 1, 1'b1);
        cnt_sel_i = 3'd1;
        step(); step();
        check("sat_cnt15", 64'(cnt_value_o), 64'd15);
        retire(32'h5100, 9, 1'b1);
        step(); step(); step();
        check("sat_hold", 64'(cnt_value_o), 64'd15);
        check("sat_drained", 64'(sb.size()), 64'd0);

        // Reset with five records queued.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) retire(32'h6000 + 32'(4 * i), i, 1'b1);
        step(); step();
        check("mid_level", 64'(fifo_level_o), 64'd5);
        rst_n = 1'b0;
        step();
        sb.delete();
        zero_model();
        check("mid_rst_valid", 64'(trace_valid_o), 64'd0);
        check("mid_rst_level", 64'(fifo_level_o),  64'd0);
        check("mid_rst_cnt",   64'(cnt_value_o),   64'd0);
        check("mid_rst_drop",  64'(drop_cnt_o),    64'd0);
        rst_n = 1'b1;
        step();
        check("mid_post_valid", 64'(trace_valid_o), 64'd0);
        read_cnts("mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
